// File: rtl/uart_hex_reporter.sv
// Formats a latched binary word as uppercase ASCII hex (MSB nibble first, optional CR LF)
// and feeds it one character at a time to a UART transmitter byte interface.
module uart_hex_reporter #(
  parameter int g_NUM_NIBBLES = 4,
  parameter int g_APPEND_CRLF = 1
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Start,
  input  logic [4*g_NUM_NIBBLES-1:0] i_Data,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic                       o_TX_DV,
  output logic [7:0]                 o_TX_Byte,
  input  logic                       i_TX_Done
);

  localparam int DATA_W    = 4 * g_NUM_NIBBLES;
  localparam int FRAME_LEN = g_NUM_NIBBLES + 2 * g_APPEND_CRLF;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        idx_reg, idx_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              dv_reg, dv_next;
  logic [7:0]        byte_reg, byte_next;

  logic [DATA_W-1:0] src_data;
  logic [3:0]        char_idx;
  logic [7:0]        char_tbl [FRAME_LEN];
  logic [7:0]        char_sel;

  // In IDLE the first character comes straight from i_Data so DV can launch on the accept edge.
  assign src_data = (state_reg == S_IDLE) ? i_Data : data_reg;
  assign char_idx = (state_reg == S_IDLE) ? 4'd0 : idx_reg + 4'd1;

  generate
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_char
      if (gi < g_NUM_NIBBLES) begin : g_digit
        logic [3:0] nib;
        assign nib = src_data[DATA_W-1-4*gi -: 4];
        assign char_tbl[gi] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else if (gi == g_NUM_NIBBLES) begin : g_cr
        assign char_tbl[gi] = 8'h0D;
      end else begin : g_lf
        assign char_tbl[gi] = 8'h0A;
      end
    end
  endgenerate

  always_comb begin
    char_sel = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (char_idx == 4'(i)) begin
        char_sel = char_tbl[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    dv_next    = 1'b0;
    byte_next  = byte_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_Start) begin
          state_next = S_WAIT;
          data_next  = i_Data;
          idx_next   = 4'd0;
          busy_next  = 1'b1;
          dv_next    = 1'b1;
          byte_next  = char_sel;
        end
      end
      S_WAIT: begin
        // A Done coincident with our own DV belongs to an earlier byte, so it is ignored.
        if (!dv_reg && i_TX_Done) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_IDLE;
            idx_next   = 4'd0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            idx_next  = idx_reg + 4'd1;
            dv_next   = 1'b1;
            byte_next = char_sel;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= 4'd0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dv_reg    <= 1'b0;
      byte_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      dv_reg    <= dv_next;
      byte_reg  <= byte_next;
    end
  end

  assign o_Busy    = busy_reg;
  assign o_Done    = done_reg;
  assign o_TX_DV   = dv_reg;
  assign o_TX_Byte = byte_reg;

endmodule
